bombe_step_controller: RTL and testbench

Upstream sequencer for the bombe's three-rotor stack: loads start positions into three clocked rotors, then issues odometer-style increment pulses (right every step, middle on right carry, left on middle carry) until all 17,576 positions are examined. It sits directly ahead of the clocked rotors, driving their increment/load inputs and their init-state inputs. It also keeps shadow copies of the rotor positions so downstream match logic can report where a hit occurred.

---
 rtl/bombe_pkg.sv | 29 ++
 rtl/bombe_step_controller_if.sv | 32 +++
 rtl/rotor_position_counter.sv | 36 +++
 rtl/bombe_step_controller.sv | 174 +++++++++++++++++
 tb/tb_bombe_step_controller.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bombe_pkg.sv
// Shared constants, state encoding and helpers for the bombe rotor step controller.
// Optional feature macro: STOP_ON_MATCH_EN (adds the HIT state).
package bombe_pkg;

    localparam int unsigned POS_W   = 5;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned STEP_W  = 15;

    localparam logic [POS_W-1:0]  ROTOR_MAX = 5'd25;
    localparam int unsigned       ROTOR_MOD = 26;
    localparam logic [STEP_W-1:0] LAST_STEP = 15'd17575;

    typedef enum logic [STATE_W-1:0] {
        StIdle,
        StLoad,
        StSettle,
        StStep,
        StDone
`ifdef STOP_ON_MATCH_EN
        , StHit
`endif
    } state_e;

    // Requested positions outside 0..25 start the rotor at 0.
    function automatic logic [POS_W-1:0] sanitize_pos(input logic [POS_W-1:0] p);
        return (p > ROTOR_MAX) ? '0 : p;
    endfunction

endpackage

// File: rtl/bombe_step_controller_if.sv
// Control/status bundle between the run requester (master) and the step controller (slave).
interface bombe_step_controller_if;
    import bombe_pkg::*;

    logic             start;
    logic [POS_W-1:0] init_pos_l;
    logic [POS_W-1:0] init_pos_m;
    logic [POS_W-1:0] init_pos_r;
    logic             hold;
    logic             match;
    logic             load;
    logic             inc_l;
    logic             inc_m;
    logic             inc_r;
    logic [POS_W-1:0] pos_l;
    logic [POS_W-1:0] pos_m;
    logic [POS_W-1:0] pos_r;
    logic             busy;
    logic             done;
    logic             hit;

    modport master (
        output start, init_pos_l, init_pos_m, init_pos_r, hold, match,
        input  load, inc_l, inc_m, inc_r, pos_l, pos_m, pos_r, busy, done, hit
    );

    modport slave (
        input  start, init_pos_l, init_pos_m, init_pos_r, hold, match,
        output load, inc_l, inc_m, inc_r, pos_l, pos_m, pos_r, busy, done, hit
    );

endinterface

// File: rtl/rotor_position_counter.sv
// Mod-26 shadow position counter with synchronous load, enable and wrap carry-out.
module rotor_position_counter
    import bombe_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [POS_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [POS_W-1:0] value_o,
    output logic             carry_o
);

    logic [POS_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i) begin
            value_d = (value_q == ROTOR_MAX) ? '0 : value_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = en_i && (value_q == ROTOR_MAX);

endmodule

// File: rtl/bombe_step_controller.sv
// Odometer sequencer for the three-rotor stack: load, settle, step until all positions seen.
// Optional macro STOP_ON_MATCH_EN: stop in HIT when match is seen in a settle evaluation cycle.
module bombe_step_controller
    import bombe_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                    clk,
    input logic                    resetn,
    bombe_step_controller_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        settle_q, settle_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              load_q, load_d;
    logic              inc_r_q, inc_r_d, inc_m_q, inc_m_d, inc_l_q, inc_l_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              pos_load, fire;
    logic [POS_W-1:0]  pos_l, pos_m, pos_r;
    logic              carry_r, carry_m, unused_carry_l;
`ifdef STOP_ON_MATCH_EN
    logic              hit_q, hit_d;
`else
    logic              unused_match;
    assign unused_match = bus.match;
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        step_d   = step_q;
        pos_load = 1'b0;
        fire     = 1'b0;
        load_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef STOP_ON_MATCH_EN
        hit_d    = hit_q;
`endif
        unique case (state_q)
            StLoad: state_d = StSettle;
            StSettle: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
`ifdef STOP_ON_MATCH_EN
                    if (bus.match) begin
                        state_d = StHit;
                        hit_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else
`endif
                    if (step_q == LAST_STEP) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StStep;
                        fire    = !bus.hold;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            // A registered pulse is live this cycle; otherwise wait for hold to drop.
            StStep: begin
                if (inc_r_q) begin
                    state_d = StSettle;
                    step_d  = step_q + 15'd1;
                end else begin
                    fire = !bus.hold;
                end
            end
            default: begin
                if (bus.start) begin
                    state_d  = StLoad;
                    pos_load = 1'b1;
                    settle_d = '0;
                    step_d   = '0;
                    load_d   = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
`ifdef STOP_ON_MATCH_EN
                    hit_d    = 1'b0;
`endif
                end
            end
        endcase
        inc_r_d = fire;
        inc_m_d = fire && (pos_r == ROTOR_MAX);
        inc_l_d = inc_m_d && (pos_m == ROTOR_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            settle_q <= '0;
            step_q   <= '0;
            load_q   <= 1'b0;
            inc_r_q  <= 1'b0;
            inc_m_q  <= 1'b0;
            inc_l_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            step_q   <= step_d;
            load_q   <= load_d;
            inc_r_q  <= inc_r_d;
            inc_m_q  <= inc_m_d;
            inc_l_q  <= inc_l_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef STOP_ON_MATCH_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end
    assign bus.hit = hit_q;
`else
    assign bus.hit = 1'b0;
`endif

    // Shadows advance on the edge that ends each pulse cycle, in step with the real rotors.
    rotor_position_counter u_rotor_r (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .load_i    (pos_load),
        .load_val_i(sanitize_pos(bus.init_pos_r)),
        .en_i      (inc_r_q),
        .value_o   (pos_r),
        .carry_o   (carry_r)
    );

    rotor_position_counter u_rotor_m (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .load_i    (pos_load),
        .load_val_i(sanitize_pos(bus.init_pos_m)),
        .en_i      (carry_r),
        .value_o   (pos_m),
        .carry_o   (carry_m)
    );

    rotor_position_counter u_rotor_l (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .load_i    (pos_load),
        .load_val_i(sanitize_pos(bus.init_pos_l)),
        .en_i      (carry_m),
        .value_o   (pos_l),
        .carry_o   (unused_carry_l)
    );

    assign bus.load  = load_q;
    assign bus.inc_r = inc_r_q;
    assign bus.inc_m = inc_m_q;
    assign bus.inc_l = inc_l_q;
    assign bus.pos_l = pos_l;
    assign bus.pos_m = pos_m;
    assign bus.pos_r = pos_r;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_bombe_step_controller.sv
// Directed bench: two controllers (SETTLE_CYCLES 2 and 1), immediate-assertion checks.
module tb_bombe_step_controller;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bombe_step_controller_if b2 ();
    bombe_step_controller_if b1 ();

    bombe_step_controller #(.SETTLE_CYCLES(2)) dut2 (
        .clk   (clk),
        .resetn(resetn),
        .bus   (b2.slave)
    );

    bombe_step_controller #(.SETTLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .resetn(resetn),
        .bus   (b1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int l, input int m, input int r);
        return 32'((l << 10) | (m << 5) | r);
    endfunction

    function automatic logic [31:0] pos2();
        return {17'd0, b2.pos_l, b2.pos_m, b2.pos_r};
    endfunction

    function automatic logic [31:0] inc2();
        return {29'd0, b2.inc_l, b2.inc_m, b2.inc_r};
    endfunction

    function automatic logic [31:0] ctl2();
        return {27'd0, b2.load, b2.busy, b2.done, b2.hit, |{b2.inc_l, b2.inc_m, b2.inc_r}};
    endfunction

    task automatic set_init2(input int l, input int m, input int r);
        b2.init_pos_l = 5'(l);
        b2.init_pos_m = 5'(m);
        b2.init_pos_r = 5'(r);
    endtask

    task automatic start2();
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        int pulses;
        int cyc;
        b1.start = 1'b0; b1.hold = 1'b0; b1.match = 1'b0;
        b1.init_pos_l = '0; b1.init_pos_m = '0; b1.init_pos_r = '0;
        b2.hold = 1'b0; b2.match = 1'b0;

        // Reset with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b2.start = 1'($urandom);
            b2.hold  = 1'($urandom);
            b2.match = 1'($urandom);
            set_init2(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)));
            tick();
            check("reset_ctl", ctl2(), 0);
            check("reset_pos", pos2(), 0);
        end
        b2.start = 1'b0; b2.hold = 1'b0; b2.match = 1'b0;
        resetn = 1'b1;
        tick(); tick(); tick();
        check("idle_after_reset", ctl2(), 0);

        // Start (3,7,30): load at N+1, first inc_r at N+4
        set_init2(3, 7, 30);
        start2();
        check("load_ctl_n1", ctl2(), 5'b11000);
        check("load_pos_clamp", pos2(), pk(3, 7, 0));
        tick();
        check("settle1_ctl_n2", ctl2(), 5'b01000);
        tick();
        check("settle2_inc_n3", inc2(), 0);
        tick();
        check("first_inc_n4", inc2(), 3'b001);
        check("pos_during_pulse", pos2(), pk(3, 7, 0));
        tick();
        check("inc_after_pulse", inc2(), 0);
        check("pos_after_step", pos2(), pk(3, 7, 1));

        // Start while busy is ignored
        set_init2(9, 9, 9);
        start2();
        check("busy_start_no_load", ctl2(), 5'b01000);
        check("busy_start_pos", pos2(), pk(3, 7, 1));

        // Asynchronous reset mid-run, between clock edges
        #2 resetn = 1'b0;
        #1;
        check("async_reset_ctl", ctl2(), 0);
        check("async_reset_pos", pos2(), 0);
        tick();
        resetn = 1'b1;
        tick();

        // Triple carry (0,25,25) -> (1,0,0)
        set_init2(0, 25, 25);
        start2();
        check("carry_load_pos", pos2(), pk(0, 25, 25));
        tick(); tick(); tick();
        check("triple_carry_inc", inc2(), 3'b111);
        tick();
        check("triple_carry_pos", pos2(), pk(1, 0, 0));
        check("triple_carry_inc_off", inc2(), 0);
        pulse_reset();

        // Hold in STEP blocks the pulse
        set_init2(0, 0, 0);
        b2.hold = 1'b1;
        start2();
        tick(); tick();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(b2.inc_r | b2.inc_m | b2.inc_l);
        end
        check("hold_no_pulse", 32'(pulses), 0);
        check("hold_pos", pos2(), pk(0, 0, 0));
        check("hold_busy", {31'd0, b2.busy}, 1);
        b2.hold = 1'b0;
        tick();
        check("hold_release_inc", inc2(), 3'b001);
        tick();
        check("hold_release_pos", pos2(), pk(0, 0, 1));

        // Hold during a non-evaluation settle cycle has no effect
        b2.hold = 1'b1;
        tick();
        b2.hold = 1'b0;
        tick();
        check("settle_hold_ignored", inc2(), 3'b001);
        pulse_reset();

`ifdef STOP_ON_MATCH_EN
        // Stop on match at (0,1,4), then restart
        set_init2(0, 1, 3);
        start2();
        tick(); tick(); tick(); tick(); tick();
        check("pre_match_pos", pos2(), pk(0, 1, 4));
        b2.match = 1'b1;
        tick();
        check("hit_ctl", ctl2(), 5'b00010);
        check("hit_pos", pos2(), pk(0, 1, 4));
        tick();
        check("hit_frozen", pos2(), pk(0, 1, 4));
        start2();
        b2.match = 1'b0;
        check("hit_restart", ctl2(), 5'b11000);
        pulse_reset();
`endif

        // Full sweep, SETTLE_CYCLES=1
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        cyc = 1;
        pulses = 0;
        while (!b1.done && cyc < 40000) begin
            pulses += int'(b1.inc_r);
            if (b1.load && b1.inc_r) pulses += 100000;
            tick();
            cyc++;
        end
        check("sweep_cycles", 32'(cyc), 2 + 17576 + 17575);
        check("sweep_inc_r_pulses", 32'(pulses), 17575);
        check("sweep_pos", {17'd0, b1.pos_l, b1.pos_m, b1.pos_r}, pk(25, 25, 25));
        check("sweep_status", {29'd0, b1.busy, b1.done, b1.hit}, 3'b010);
        tick(); tick();
        check("done_sticky", {29'd0, b1.busy, b1.done, b1.inc_r}, 3'b010);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        check("done_restart", {28'd0, b1.load, b1.busy, b1.done, b1.inc_r}, 4'b1100);
        check("done_restart_pos", {17'd0, b1.pos_l, b1.pos_m, b1.pos_r}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
